// File: rtl/full_adder_4bit.sv
// ----------------------------------------------------------------------------
// full_adder_4bit
//
// Unsigned 4-bit ripple-carry adder built from four chained single-bit
// full-adder cells.
// - Combinational outputs: {Cout, Sum} = A + B + Cin, plus the per-cell
//   carries and a two's-complement overflow flag.
// - Registered outputs: a one-cycle copy of Sum, Cout and Ovf. This stage
//   samples on every rising clk and has no enable.
//
// Ports:
//   clk     in   1  clock for the registered result stage
//   rst     in   1  asynchronous active-high reset; clears the registered stage only
//   A       in   4  addend (unsigned, also read as two's complement for Ovf)
//   B       in   4  addend (unsigned, also read as two's complement for Ovf)
//   Cin     in   1  carry-in to cell 0
//   Sum     out  4  combinational (A + B + Cin) mod 16
//   Cout    out  1  combinational carry-out of cell 3
//   Carry   out  4  combinational carry-out of each cell; Carry[3] == Cout
//   Ovf     out  1  combinational signed overflow, Carry[3] ^ Carry[2]
//   Sum_r   out  4  Sum registered
//   Cout_r  out  1  Cout registered
//   Ovf_r   out  1  Ovf registered
// ----------------------------------------------------------------------------
module full_adder_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout,
    output logic [3:0] Carry,
    output logic       Ovf,
    output logic [3:0] Sum_r,
    output logic       Cout_r,
    output logic       Ovf_r
);

    // Sum bit of one full-adder cell.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Carry-out of one full-adder cell: generate, or propagate the incoming carry.
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (c & (a ^ b));
    endfunction

    logic [3:0] sum_s;
    logic [3:0] carry_s;
    logic       ovf_s;

    // Ripple chain: cell 0 takes Cin, and each later cell takes the previous cell's carry.
    always_comb begin
        sum_s      = 4'b0000;
        carry_s    = 4'b0000;
        sum_s[0]   = fa_sum(A[0], B[0], Cin);
        carry_s[0] = fa_carry(A[0], B[0], Cin);
        for (int i = 1; i < 4; i++) begin
            sum_s[i]   = fa_sum(A[i], B[i], carry_s[i-1]);
            carry_s[i] = fa_carry(A[i], B[i], carry_s[i-1]);
        end
    end

    // Signed overflow occurs when the carry into the sign bit differs from the carry out of it.
    always_comb begin
        ovf_s = carry_s[3] ^ carry_s[2];
    end

    // Drive the combinational outputs.
    always_comb begin
        Sum   = sum_s;
        Carry = carry_s;
        Cout  = carry_s[3];
        Ovf   = ovf_s;
    end

    // Result register: capture every cycle; reset clears it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sum_r  <= 4'b0000;
            Cout_r <= 1'b0;
            Ovf_r  <= 1'b0;
        end else begin
            Sum_r  <= sum_s;
            Cout_r <= carry_s[3];
            Ovf_r  <= ovf_s;
        end
    end

endmodule

// File: tb/tb_full_adder_4bit.sv
// ----------------------------------------------------------------------------
// tb_full_adder_4bit
//
// Self-checking bench for full_adder_4bit. Expected results come from an
// arithmetic model. The model derives each carry from partial sums rather
// than from the cell equations.
// - Combinational results are pushed to comb_q when stimulus is applied and
//   popped 1 time unit later.
// - Registered results are pushed to reg_q before a clock edge and popped
//   just after that edge.
// ----------------------------------------------------------------------------
module tb_full_adder_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] Sum;
    logic       Cout;
    logic [3:0] Carry;
    logic       Ovf;
    logic [3:0] Sum_r;
    logic       Cout_r;
    logic       Ovf_r;

    int n_vec  = 0;
    int n_miss = 0;

    // Entry layout: {carry[3:0], ovf, cout, sum[3:0]}
    logic [9:0] comb_q [$];
    // Entry layout: {ovf, cout, sum[3:0]}
    logic [5:0] reg_q  [$];

    full_adder_4bit dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .Sum    (Sum),
        .Cout   (Cout),
        .Carry  (Carry),
        .Ovf    (Ovf),
        .Sum_r  (Sum_r),
        .Cout_r (Cout_r),
        .Ovf_r  (Ovf_r)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog that stops the run if it overruns its time budget.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    // Reference model of the adder.
    function automatic logic [9:0] model(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] tot;
        logic [4:0] part;
        logic [4:0] m;
        logic [3:0] cy;
        logic       ov;
        tot = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cy  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            m     = (5'd2 << i) - 5'd1;
            part  = ({1'b0, a} & m) + ({1'b0, b} & m) + {4'b0000, cin};
            cy[i] = part[i+1];
        end
        ov = (a[3] == b[3]) && (tot[3] != a[3]);
        return {cy, ov, tot[4], tot[3:0]};
    endfunction

    task automatic check_val(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (A=%0h B=%0h Cin=%0b)", tag, observed, expected, A, B, Cin);
        end
    endtask

    // Apply one input vector, queue its expected result, then check it 1 unit later.
    task automatic drive_comb(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic full);
        logic [9:0] e;
        A   = a;
        B   = b;
        Cin = cin;
        comb_q.push_back(model(a, b, cin));
        #1;
        e = comb_q.pop_front();
        check_val("sum",  {4'h0, Sum},   {4'h0, e[3:0]});
        check_val("cout", {7'h00, Cout}, {7'h00, e[4]});
        if (full) begin
            check_val("carry", {4'h0, Carry}, {4'h0, e[9:6]});
            check_val("ovf",   {7'h00, Ovf},  {7'h00, e[5]});
        end
    endtask

    // Queue the registered result expected from the current inputs at the next edge.
    task automatic push_reg();
        logic [9:0] e;
        e = model(A, B, Cin);
        reg_q.push_back({e[5], e[4], e[3:0]});
    endtask

    task automatic check_reg(input string tag, input logic [5:0] e);
        check_val({tag, "_sum_r"},  {4'h0, Sum_r},   {4'h0, e[3:0]});
        check_val({tag, "_cout_r"}, {7'h00, Cout_r}, {7'h00, e[4]});
        check_val({tag, "_ovf_r"},  {7'h00, Ovf_r},  {7'h00, e[5]});
    endtask

    // Main stimulus sequence.
    initial begin
        logic [5:0] e;
        rst = 1'b1;
        A   = 4'h0;
        B   = 4'h0;
        Cin = 1'b0;
        #1;
        check_reg("reset", 6'b000000);

        // Directed combinational vectors.
        drive_comb(4'h0, 4'h0, 1'b0, 1'b1);   // minimum input
        drive_comb(4'hF, 4'h1, 1'b0, 1'b1);   // carry through every cell
        drive_comb(4'hF, 4'hF, 1'b1, 1'b1);   // maximum input
        drive_comb(4'h7, 4'h1, 1'b0, 1'b1);   // positive overflow
        drive_comb(4'h8, 4'h8, 1'b0, 1'b1);   // negative overflow
        drive_comb(4'h5, 4'hA, 1'b1, 1'b1);   // Cin alone ripples through A+B==15
        drive_comb(4'h5, 4'hA, 1'b0, 1'b1);   // A+B==15 without carry-in
        drive_comb(4'h9, 4'h8, 1'b1, 1'b1);

        // Random combinational vectors.
        for (int i = 0; i < 200; i++) begin
            drive_comb(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b1);
        end

        // The registers must stay cleared while rst is held across edges.
        check_reg("rst_hold", 6'b000000);

        // Release reset between edges, then capture 9 + 8 + 1.
        @(negedge clk);
        rst = 1'b0;
        A   = 4'h9;
        B   = 4'h8;
        Cin = 1'b1;
        push_reg();
        @(posedge clk);
        #1;
        e = reg_q.pop_front();
        check_reg("cap1", e);
        check_reg("cap1_const", 6'b110010);

        // Change the inputs mid-cycle: the register holds until the next edge.
        #3;
        A   = 4'h3;
        B   = 4'h4;
        Cin = 1'b0;
        #1;
        check_reg("hold", e);
        push_reg();
        @(posedge clk);
        #1;
        check_reg("cap2", reg_q.pop_front());

        // Capture 9 + 8 + 1 again, then assert reset between edges.
        A   = 4'h9;
        B   = 4'h8;
        Cin = 1'b1;
        push_reg();
        @(posedge clk);
        #1;
        check_reg("cap3", reg_q.pop_front());
        #2;
        rst = 1'b1;
        #1;
        check_reg("async_rst", 6'b000000);
        check_val("rst_comb_sum", {4'h0, Sum}, 8'h02);
        check_val("rst_comb_cout", {7'h00, Cout}, 8'h01);
        @(posedge clk);
        #1;
        check_reg("rst_edge", 6'b000000);

        // Release reset: the first edge captures the current sum.
        @(negedge clk);
        rst = 1'b0;
        push_reg();
        @(posedge clk);
        #1;
        check_reg("post_rst", reg_q.pop_front());

        // A few random registered captures.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            A   = 4'($urandom_range(15));
            B   = 4'($urandom_range(15));
            Cin = 1'($urandom_range(1));
            push_reg();
            @(posedge clk);
            #1;
            check_reg("rnd_reg", reg_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
